branch_target_predictor: RTL and testbench

Direct-mapped branch target buffer with per-entry saturating direction counters for the five-stage pipeline. The IF stage looks up the current PC combinationally and receives a predicted next PC in the same cycle. The EX stage reports each resolved control-flow instruction; the block trains its state, flags mispredictions, and supplies the corrected PC. Optional 32-bit statistics counters sit alongside the existing cycle and branch counters.

---
 rtl/branch_target_predictor_if.sv | 50 +++++
 rtl/branch_target_predictor.sv | 181 ++++++++++++++++++
 tb/tb_branch_target_predictor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if
// Bundles the IF-stage lookup port, the EX-stage resolve/update port and the
// statistics outputs of the branch target predictor.
//   master : pipeline side (drives lookup and update requests)
//   slave  : predictor side (returns prediction, redirect and statistics)
// Signals:
//   lkp_en, lkp_pc                      IF lookup request
//   pred_taken, pred_pc                 same-cycle prediction
//   upd_valid, upd_pc, upd_uncond,
//   upd_taken, upd_target,
//   upd_pred_taken, upd_pred_pc         EX resolve report
//   mispredict, correct_pc              redirect request
//   stat_lookups, stat_hits,
//   stat_mispredicts                    event counters (zero when not built)
interface branch_target_predictor_if;
    logic        lkp_en;
    logic [31:0] lkp_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_uncond;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_pc;
    logic        mispredict;
    logic [31:0] correct_pc;

    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;

    modport master (
        output lkp_en, lkp_pc,
        output upd_valid, upd_pc, upd_uncond, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_pc,
        input  pred_taken, pred_pc, mispredict, correct_pc,
        input  stat_lookups, stat_hits, stat_mispredicts
    );

    modport slave (
        input  lkp_en, lkp_pc,
        input  upd_valid, upd_pc, upd_uncond, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_pc,
        output pred_taken, pred_pc, mispredict, correct_pc,
        output stat_lookups, stat_hits, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// branch_target_predictor
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. The IF stage looks up lkp_pc combinationally and gets a predicted
// next PC in the same cycle; the EX stage reports resolved control flow, which
// trains the table one cycle later and produces a same-cycle redirect.
//
// Parameters:
//   ENTRIES    number of entries, power of two (2..256)
//   CTR_BITS   direction counter width (1..4)
//   ADDR_BITS  byte-address bits kept in tag and target; must exceed
//              log2(ENTRIES)+2 so that the tag is at least one bit wide
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (clears valid bits, counters, stats)
//   bus   branch_target_predictor_if.slave (lookup, update, redirect, stats)
//
// Build option:
//   BP_STATS_EN  when defined, the 32-bit lookup/hit/mispredict counters are
//                built; otherwise the stat_* outputs are tied to zero.
module branch_target_predictor #(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int ADDR_BITS = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    branch_target_predictor_if.slave    bus
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - 2;
    localparam int TGT_BITS   = ADDR_BITS - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_ONE << (CTR_BITS - 1);

    // ------------------------------------------------------------------
    // Table storage. Only valid and ctr are reset; tag and target are
    // qualified by valid, so their contents after reset are irrelevant.
    // ------------------------------------------------------------------
    logic                valid_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [TGT_BITS-1:0] tgt_q   [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup path (IF stage), purely from registered state: a same-cycle
    // update to the same index is not bypassed.
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] lkp_idx;
    logic [TAG_BITS-1:0]   lkp_tag;
    logic                  lkp_hit;
    logic                  lkp_taken;
    logic [31:0]           lkp_target;

    assign lkp_idx    = bus.lkp_pc[INDEX_BITS+1:2];
    assign lkp_tag    = bus.lkp_pc[ADDR_BITS-1:INDEX_BITS+2];
    assign lkp_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken  = lkp_hit && ctr_q[lkp_idx][CTR_BITS-1];
    // Stored target is word-aligned and zero-extended above ADDR_BITS.
    assign lkp_target = 32'({tgt_q[lkp_idx], 2'b00});

    assign bus.pred_taken = lkp_taken;
    assign bus.pred_pc    = lkp_taken ? lkp_target : (bus.lkp_pc + 32'd4);

    // ------------------------------------------------------------------
    // Resolve path (EX stage): redirect and training decision.
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;
    logic                  actual_taken;
    logic [31:0]           correct_pc;
    logic [CTR_BITS-1:0]   cur_ctr;
    logic [CTR_BITS-1:0]   ctr_inc;
    logic [CTR_BITS-1:0]   ctr_dec;

    assign upd_idx      = bus.upd_pc[INDEX_BITS+1:2];
    assign upd_tag      = bus.upd_pc[ADDR_BITS-1:INDEX_BITS+2];
    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign actual_taken = bus.upd_taken | bus.upd_uncond;
    assign correct_pc   = bus.upd_taken ? bus.upd_target : (bus.upd_pc + 32'd4);

    assign cur_ctr = ctr_q[upd_idx];
    assign ctr_inc = (cur_ctr == CTR_MAX)  ? CTR_MAX  : (cur_ctr + CTR_ONE);
    assign ctr_dec = (cur_ctr == CTR_ZERO) ? CTR_ZERO : (cur_ctr - CTR_ONE);

    assign bus.correct_pc = correct_pc;
    assign bus.mispredict = bus.upd_valid &&
                            ((bus.upd_pred_taken != actual_taken) ||
                             (bus.upd_pred_pc != correct_pc));

    // Training decision:
    //   wr_entry : taken resolve, (re)write tag, target and counter
    //   wr_ctr   : not-taken resolve that hits, counter only
    logic                wr_entry;
    logic                wr_ctr;
    logic [CTR_BITS-1:0] new_ctr;

    always_comb begin
        wr_entry = 1'b0;
        wr_ctr   = 1'b0;
        new_ctr  = cur_ctr;
        if (bus.upd_valid) begin
            if (actual_taken) begin
                wr_entry = 1'b1;
                if (bus.upd_uncond) begin
                    new_ctr = CTR_MAX;
                end else if (upd_hit) begin
                    new_ctr = ctr_inc;
                end else begin
                    // Fresh allocation starts weakly taken.
                    new_ctr = CTR_WEAK;
                end
            end else if (upd_hit) begin
                // Entry stays valid even when the counter bottoms out.
                wr_ctr  = 1'b1;
                new_ctr = ctr_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= '0;
            end
        end else if (wr_entry) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= new_ctr;
        end else if (wr_ctr) begin
            ctr_q[upd_idx]   <= new_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_entry) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= bus.upd_target[ADDR_BITS-1:2];
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] hits_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            if (bus.lkp_en) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (bus.lkp_en && lkp_hit) begin
                hits_q <= hits_q + 32'd1;
            end
            if (bus.mispredict) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign bus.stat_lookups     = lookups_q;
    assign bus.stat_hits        = hits_q;
    assign bus.stat_mispredicts = mispredicts_q;
`else
    assign bus.stat_lookups     = 32'd0;
    assign bus.stat_hits        = 32'd0;
    assign bus.stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor
// Drives directed and random lookup/update traffic into branch_target_predictor.
// A driver computes the expected outputs from a behavioural table model and
// queues them; a monitor on the falling edge pops and compares.
module tb_branch_target_predictor;

    localparam int ENTRIES   = 16;
    localparam int CTR_BITS  = 2;
    localparam int ADDR_BITS = 12;
    localparam int CTR_MAX   = (1 << CTR_BITS) - 1;
    localparam int CTR_HALF  = 1 << (CTR_BITS - 1);
    localparam logic [31:0] AMASK = ((32'd1 << ADDR_BITS) - 32'd1) & ~32'd3;
`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_target_predictor_if bus();

    branch_target_predictor #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        pt;
        logic [31:0] ppc;
        logic        mp;
        logic [31:0] cpc;
        logic [31:0] sl;
        logic [31:0] sh;
        logic [31:0] sm;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model: each slot remembers the aligned address bits of the
    // branch it holds, its masked target and a plain integer confidence.
    bit          m_valid [ENTRIES];
    logic [31:0] m_addr  [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] cnt_l, cnt_h, cnt_m;

    // stimulus variables for the current cycle
    bit          s_rst, s_le, s_uv, s_uu, s_ut, s_upt;
    logic [31:0] s_lp, s_up, s_utg, s_upp;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_addr[slot(pc)] == (pc & AMASK));
    endfunction

    task automatic m_predict(input logic [31:0] pc, output bit taken, output logic [31:0] npc);
        taken = m_hit(pc) && (m_ctr[slot(pc)] >= CTR_HALF);
        npc   = taken ? m_tgt[slot(pc)] : pc + 32'd4;
    endtask

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        cnt_l = 0;
        cnt_h = 0;
        cnt_m = 0;
    endtask

    task automatic m_train();
        int  i;
        bit  hit;
        i   = slot(s_up);
        hit = m_hit(s_up);
        if (s_ut || s_uu) begin
            if (hit) m_ctr[i] = s_uu ? CTR_MAX : ((m_ctr[i] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[i] + 1);
            else     m_ctr[i] = s_uu ? CTR_MAX : CTR_HALF;
            m_valid[i] = 1'b1;
            m_addr[i]  = s_up & AMASK;
            m_tgt[i]   = s_utg & AMASK;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
    endtask

    // Apply one cycle of stimulus, queue its expectation, advance the model.
    task automatic step();
        exp_t e;
        bit   act;
        rst                = s_rst;
        bus.lkp_en         = s_le;
        bus.lkp_pc         = s_lp;
        bus.upd_valid      = s_uv;
        bus.upd_pc         = s_up;
        bus.upd_uncond     = s_uu;
        bus.upd_taken      = s_ut;
        bus.upd_target     = s_utg;
        bus.upd_pred_taken = s_upt;
        bus.upd_pred_pc    = s_upp;

        m_predict(s_lp, act, e.ppc);
        e.pt  = act;
        e.cpc = s_ut ? s_utg : s_up + 32'd4;
        e.mp  = s_uv && ((s_upt != (s_ut || s_uu)) || (s_upp != e.cpc));
        e.sl  = STATS ? cnt_l : 32'd0;
        e.sh  = STATS ? cnt_h : 32'd0;
        e.sm  = STATS ? cnt_m : 32'd0;
        sb_q.push_back(e);

        if (s_rst) begin
            m_reset();
        end else begin
            if (s_le) cnt_l = cnt_l + 1;
            if (s_le && m_hit(s_lp)) cnt_h = cnt_h + 1;
            if (e.mp) cnt_m = cnt_m + 1;
            if (s_uv) m_train();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic no_upd();
        s_uv = 0; s_up = 0; s_uu = 0; s_ut = 0; s_utg = 0; s_upt = 0; s_upp = 32'd4;
    endtask

    // Update carrying the prediction the model would have made in IF.
    task automatic upd(input logic [31:0] pc, input bit uu, input bit ut, input logic [31:0] tgt);
        bit          pt;
        logic [31:0] pp;
        m_predict(pc, pt, pp);
        s_uv = 1; s_up = pc; s_uu = uu; s_ut = ut; s_utg = tgt; s_upt = pt; s_upp = pp;
    endtask

    task automatic lookup(input logic [31:0] pc);
        s_le = 1; s_lp = pc;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s vec %0d: got %08h expected %08h", name, n_vec, act, exp_v);
        end
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the queue.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pred_taken", 32'(bus.pred_taken), 32'(e.pt));
            chk("pred_pc", bus.pred_pc, e.ppc);
            chk("mispredict", 32'(bus.mispredict), 32'(e.mp));
            chk("correct_pc", bus.correct_pc, e.cpc);
            chk("stat_lookups", bus.stat_lookups, e.sl);
            chk("stat_hits", bus.stat_hits, e.sh);
            chk("stat_mispredicts", bus.stat_mispredicts, e.sm);
            n_vec++;
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFF_F000);
        return pc;
    endfunction

    initial begin
        s_rst = 1; s_le = 0; s_lp = 0;
        no_upd();
        rst = 1;
        bus.lkp_en = 0; bus.lkp_pc = 0;
        bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_uncond = 0; bus.upd_taken = 0;
        bus.upd_target = 0; bus.upd_pred_taken = 0; bus.upd_pred_pc = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        s_rst = 0;

        // empty table, five counted lookups, then observe the counters
        for (int i = 0; i < 5; i++) begin lookup(32'h40); step(); end
        s_le = 0; step();

        // first taken conditional at 0x40 mispredicts, then predicts taken
        lookup(32'h40);
        s_uv = 1; s_up = 32'h40; s_uu = 0; s_ut = 1; s_utg = 32'h100; s_upt = 0; s_upp = 32'h44;
        step();
        no_upd(); step();

        // three not-taken resolves walk the counter down and saturate at 0
        for (int i = 0; i < 3; i++) begin upd(32'h40, 0, 0, 32'h0); step(); end
        no_upd(); step();

        // alias: 0x80 evicts 0x40 from the same slot
        upd(32'h40, 0, 1, 32'h100); step();
        upd(32'h80, 0, 1, 32'h180); step();
        no_upd(); lookup(32'h40); step();
        lookup(32'h80); step();

        // mid-operation reset, then same-cycle lookup and update, no bypass
        s_rst = 1; step();
        s_rst = 0;
        lookup(32'h40);
        s_uv = 1; s_up = 32'h40; s_uu = 0; s_ut = 1; s_utg = 32'h200; s_upt = 0; s_upp = 32'h44;
        step();
        no_upd(); step();

        // JR predicted correctly, then same direction with a changed target
        lookup(32'h60);
        s_uv = 1; s_up = 32'h60; s_uu = 1; s_ut = 1; s_utg = 32'h300; s_upt = 1; s_upp = 32'h300;
        step();
        s_utg = 32'h304; step();
        no_upd(); step();

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 99) == 0);
            s_le  = $urandom_range(0, 1);
            s_lp  = rand_pc();
            if ($urandom_range(0, 1) == 1) begin
                upd(rand_pc(), ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
                    $urandom & 32'hFFFF_FFFC);
                if ($urandom_range(0, 3) == 0) begin
                    s_upt = $urandom_range(0, 1);
                    s_upp = $urandom;
                end
            end else begin
                no_upd();
            end
            step();
        end
        s_rst = 0; s_le = 0; no_upd(); step();

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
